endstop_emu: RTL and testbench

- Endstop emulator: produces a bouncy, switch-like digital signal when a motion position crosses a programmable trigger point.
- It is the transmitter end of the endstop debounce path. Its sig_out feeds a debounce input for closed-loop self-test without real switches, and is also driven to a spare pin for bench checks.
- Bounce length and toggle period are programmable, so the debounce timeout and max-bounce measurement can be exercised deterministically.

---
 rtl/endstop_emu.sv | 148 ++++++++++++++
 tb/tb_endstop_emu.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/endstop_emu.sv
// rtl/endstop_emu.sv - bouncy switch emulator triggered by a position crossing a trigger point
// Optional ENDSTOP_EMU_LFSR_EN: pseudo-random toggle intervals capped by bounce_period.
module endstop_emu #(
    parameter int POS_W = 32,
    parameter int LEN_W = 16,
    parameter int PER_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic [POS_W-1:0] pos_in,
    input  logic [POS_W-1:0] trig_pos,
    input  logic             invert,
    input  logic [LEN_W-1:0] bounce_len,
    input  logic [PER_W-1:0] bounce_period,
    output logic             sig_out,
    output logic [7:0]       edges,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        BOUNCE_ON  = 2'd1,
        ACTIVE     = 2'd2,
        BOUNCE_OFF = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic             l_q, l_d;
    logic [LEN_W-1:0] timer_q, timer_d;
    logic [PER_W-1:0] tog_q, tog_d;
    logic [7:0]       edges_q, edges_d;
    logic             busy_q, busy_d;
    logic             sig_q, sig_d;
    logic             sig_vld_q;
    logic             hit;
    logic             target;
    logic [PER_W-1:0] per_cmp;

`ifdef ENDSTOP_EMU_LFSR_EN
    logic [7:0] lfsr_q, lfsr_d;

    // Galois right-shift form of x^8+x^6+x^5+x^4+1
    function automatic logic [7:0] lfsr_step(input logic [7:0] v);
        logic [7:0] n;
        n = v >> 1;
        if (v[0]) n = n ^ 8'hB8;
        return n;
    endfunction

    assign per_cmp = bounce_period & PER_W'(lfsr_q);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) lfsr_q <= 8'hA5;
        else       lfsr_q <= lfsr_d;
    end
`else
    assign per_cmp = bounce_period;
`endif

    assign hit    = ($signed(pos_in) >= $signed(trig_pos));
    assign target = (state_q == BOUNCE_ON);

    // Until the first clocked update, the output follows invert so the reset level tracks it.
    assign sig_out = sig_vld_q ? sig_q : invert;
    assign edges   = edges_q;
    assign busy    = busy_q;

    always_comb begin
        state_d = state_q;
        l_d     = l_q;
        timer_d = timer_q;
        tog_d   = tog_q;
`ifdef ENDSTOP_EMU_LFSR_EN
        lfsr_d  = lfsr_q;
`endif
        if (!enable) begin
            state_d = IDLE;
            l_d     = 1'b0;
            timer_d = '0;
            tog_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    l_d = 1'b0;
                    if (hit) begin
                        l_d     = 1'b1;
                        timer_d = '0;
                        tog_d   = '0;
                        state_d = (bounce_len == '0) ? ACTIVE : BOUNCE_ON;
                    end
                end
                ACTIVE: begin
                    l_d = 1'b1;
                    if (!hit) begin
                        l_d     = 1'b0;
                        timer_d = '0;
                        tog_d   = '0;
                        state_d = (bounce_len == '0) ? IDLE : BOUNCE_OFF;
                    end
                end
                default: begin
                    if (timer_q == bounce_len) begin
                        l_d     = target;
                        state_d = target ? ACTIVE : IDLE;
                    end else begin
                        timer_d = timer_q + 1'b1;
                        if (tog_q == per_cmp) begin
                            l_d   = ~l_q;
                            tog_d = '0;
`ifdef ENDSTOP_EMU_LFSR_EN
                            lfsr_d = lfsr_step(lfsr_q);
`endif
                        end else begin
                            tog_d = tog_q + 1'b1;
                        end
                    end
                end
            endcase
        end
        sig_d   = l_d ^ invert;
        edges_d = edges_q + {7'd0, (sig_d != sig_out)};
        busy_d  = (state_d == BOUNCE_ON) || (state_d == BOUNCE_OFF);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            l_q       <= 1'b0;
            timer_q   <= '0;
            tog_q     <= '0;
            edges_q   <= '0;
            busy_q    <= 1'b0;
            sig_q     <= 1'b0;
            sig_vld_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            l_q       <= l_d;
            timer_q   <= timer_d;
            tog_q     <= tog_d;
            edges_q   <= edges_d;
            busy_q    <= busy_d;
            sig_q     <= sig_d;
            sig_vld_q <= 1'b1;
        end
    end

endmodule

// File: tb/tb_endstop_emu.sv
// tb/tb_endstop_emu.sv - directed self-checking bench for endstop_emu
module tb_endstop_emu;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic [31:0] pos_in;
    logic [31:0] trig_pos;
    logic        invert;
    logic [15:0] bounce_len;
    logic [7:0]  bounce_period;
    logic        sig_out;
    logic [7:0]  edges;
    logic        busy;

    int total = 0;
    int bad   = 0;

    // Logical level after edge j of a len=10, period=2 bounce-on window (bit j)
    logic [11:0] on_pat;

    endstop_emu #(.POS_W(32), .LEN_W(16), .PER_W(8)) dut (
        .clk           (clk),
        .reset         (reset),
        .enable        (enable),
        .pos_in        (pos_in),
        .trig_pos      (trig_pos),
        .invert        (invert),
        .bounce_len    (bounce_len),
        .bounce_period (bounce_period),
        .sig_out       (sig_out),
        .edges         (edges),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic run_window(input string tag, input logic flip, input logic inv);
        for (int j = 0; j < 12; j++) begin
            tick(1);
            check($sformatf("%s_sig_e%0d", tag, j), {31'd0, sig_out}, {31'd0, on_pat[j] ^ flip ^ inv});
            check($sformatf("%s_busy_e%0d", tag, j), {31'd0, busy}, (j <= 10) ? 32'd1 : 32'd0);
        end
    endtask

    initial begin
        on_pat        = 12'b1001_1100_0111;
        reset         = 1'b1;
        enable        = 1'b1;
        invert        = 1'b0;
        trig_pos      = 32'd100;
        pos_in        = 32'd99;
        bounce_len    = 16'd10;
        bounce_period = 8'd2;

        tick(2);
        check("rst_sig", {31'd0, sig_out}, 32'd0);
        check("rst_edges", {24'd0, edges}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        reset = 1'b0;
        tick(5);
        check("idle_sig", {31'd0, sig_out}, 32'd0);
        check("idle_edges", {24'd0, edges}, 32'd0);
        check("idle_busy", {31'd0, busy}, 32'd0);

        pos_in = 32'd100;
        run_window("on", 1'b0, 1'b0);
        check("on_edges", {24'd0, edges}, 32'd5);
        tick(3);
        check("active_sig", {31'd0, sig_out}, 32'd1);
        check("active_busy", {31'd0, busy}, 32'd0);

        pos_in = 32'd50;
        run_window("off", 1'b1, 1'b0);
        check("off_edges", {24'd0, edges}, 32'd10);

        invert = 1'b1;
        tick(1);
        check("inv_idle_sig", {31'd0, sig_out}, 32'd1);
        check("inv_idle_edges", {24'd0, edges}, 32'd11);
        pos_in = 32'd100;
        run_window("inv_on", 1'b0, 1'b1);
        check("inv_on_edges", {24'd0, edges}, 32'd16);
        pos_in = 32'd50;
        run_window("inv_off", 1'b1, 1'b1);
        check("inv_off_edges", {24'd0, edges}, 32'd21);
        invert = 1'b0;
        tick(1);
        check("uninv_sig", {31'd0, sig_out}, 32'd0);
        check("uninv_edges", {24'd0, edges}, 32'd22);

        reset = 1'b1;
        #1;
        check("rst2_edges", {24'd0, edges}, 32'd0);
        reset      = 1'b0;
        bounce_len = 16'd0;
        pos_in     = 32'd100;
        tick(1);
        check("len0_rise_sig", {31'd0, sig_out}, 32'd1);
        check("len0_rise_busy", {31'd0, busy}, 32'd0);
        check("len0_rise_edges", {24'd0, edges}, 32'd1);
        tick(2);
        check("len0_hold_sig", {31'd0, sig_out}, 32'd1);
        check("len0_hold_busy", {31'd0, busy}, 32'd0);
        pos_in = 32'd50;
        tick(1);
        check("len0_fall_sig", {31'd0, sig_out}, 32'd0);
        check("len0_fall_busy", {31'd0, busy}, 32'd0);
        check("len0_fall_edges", {24'd0, edges}, 32'd2);

        trig_pos = -32'sd3;
        pos_in   = -32'sd5;
        tick(3);
        check("neg_below_sig", {31'd0, sig_out}, 32'd0);
        pos_in = -32'sd3;
        tick(1);
        check("neg_equal_sig", {31'd0, sig_out}, 32'd1);
        trig_pos = -32'sd1;
        pos_in   = -32'sd2;
        tick(1);
        check("neg_drop_sig", {31'd0, sig_out}, 32'd0);
        pos_in = 32'd0;
        tick(1);
        check("zero_vs_m1_sig", {31'd0, sig_out}, 32'd1);
        pos_in = -32'sd2;
        tick(1);
        check("back_below_sig", {31'd0, sig_out}, 32'd0);

        trig_pos      = 32'd100;
        bounce_len    = 16'd10;
        bounce_period = 8'd5;
        pos_in        = 32'd100;
        tick(1);
        check("en_win_sig", {31'd0, sig_out}, 32'd1);
        check("en_win_busy", {31'd0, busy}, 32'd1);
        tick(4);
        check("en_t4_sig", {31'd0, sig_out}, 32'd1);
        check("en_t4_busy", {31'd0, busy}, 32'd1);
        enable = 1'b0;
        tick(1);
        check("en_off_sig", {31'd0, sig_out}, 32'd0);
        check("en_off_busy", {31'd0, busy}, 32'd0);
        tick(3);
        check("en_off_hold_sig", {31'd0, sig_out}, 32'd0);
        check("en_off_hold_busy", {31'd0, busy}, 32'd0);

        enable = 1'b1;
        tick(2);
        check("pre_rst_busy", {31'd0, busy}, 32'd1);
        reset = 1'b1;
        #1;
        check("async_rst_sig", {31'd0, sig_out}, 32'd0);
        check("async_rst_busy", {31'd0, busy}, 32'd0);
        check("async_rst_edges", {24'd0, edges}, 32'd0);
        reset = 1'b0;
        tick(1);
        check("post_rst_sig", {31'd0, sig_out}, 32'd1);
        check("post_rst_busy", {31'd0, busy}, 32'd1);
        check("post_rst_edges", {24'd0, edges}, 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
